// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak front-end.
//   lane_t   : one 64-bit Keccak lane
//   state_t  : full 5x5 lane array, lane i = x+5y at [y][x]
//   fsm_t    : pad-feeder state encoding
//   DOMAIN_SHA3 / PAD_END : SHA-3 domain-separation byte and final pad bit
//   RATE_SHA3_256         : rate in lanes for SHA3-256
package keccak_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [0:4][0:4] state_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEND   = 2'd1,
    PADBLK = 2'd2
  } fsm_t;

  localparam logic [7:0] DOMAIN_SHA3   = 8'h06;
  localparam logic [7:0] PAD_END       = 8'h80;
  localparam int         RATE_SHA3_256 = 17;

endpackage

// File: rtl/keccak_pad_lane.sv
// Combinational padding of the single lane being written.
// Ports:
//   word          : incoming message word (byte 0 at [7:0])
//   n             : valid bytes in word, 0..8
//   domain        : domain-separation byte placed at byte n
//   is_final_lane : lane is the last rate lane, so byte 7 gets OR'd with 0x80
//   is_pad_lane   : word is the final message word; mask bytes above n
//   lane          : padded lane
module keccak_pad_lane
  import keccak_pkg::*;
(
  input  lane_t      word,
  input  logic [3:0] n,
  input  logic [7:0] domain,
  input  logic       is_final_lane,
  input  logic       is_pad_lane,
  output lane_t      lane
);

  always_comb begin
    lane = word;
    if (is_pad_lane) begin
      for (int b = 0; b < 8; b++) begin
        if (4'(b) == n) begin
          lane[8*b +: 8] = domain;
        end else if (4'(b) > n) begin
          lane[8*b +: 8] = 8'h00;
        end
      end
    end
    // Applied after the domain byte so a coinciding byte becomes domain|0x80.
    if (is_final_lane) begin
      lane[63:56] = lane[63:56] | PAD_END;
    end
  end

endmodule

// File: rtl/keccak_pad_feeder.sv
// Packs a 64-bit little-endian word stream into rate-sized Keccak blocks,
// applies SHA-3 multi-rate padding and presents each block as a full 5x5
// lane array with a valid/ready handshake. Capacity lanes are always zero.
// Optional build macro: KECCAK_PAD_DOMAIN_EN adds pad_domain[7:0], which
// replaces the fixed 0x06 domain byte (e.g. 0x1F for SHAKE).
// Ports:
//   clk, nrst       : clock, asynchronous active-low reset
//   s_data/s_valid  : message word and its valid
//   s_last/s_bytes  : final word flag and its valid byte count (0..8)
//   s_ready         : feeder accepts a word (FILL only)
//   blk_data        : block, lane i = x+5y at blk_data[y][x]
//   blk_valid/ready : block handshake
//   blk_last        : block carries the padding
//
// state  | meaning
// FILL   | accepting message words into the lane buffer
// SEND   | presenting the buffered block, waiting for blk_ready
// PADBLK | building a padding-only block after an exact-fit message
module keccak_pad_feeder
  import keccak_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int RATE_LANES = RATE_SHA3_256
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [WIDTH-1:0]               s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  input  logic [3:0]                     s_bytes,
`ifdef KECCAK_PAD_DOMAIN_EN
  input  logic [7:0]                     pad_domain,
`endif
  output logic                           s_ready,
  output logic [0:4][0:4][WIDTH-1:0]     blk_data,
  output logic                           blk_valid,
  output logic                           blk_last,
  input  logic                           blk_ready
);

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);
  localparam lane_t      END_LANE  = {PAD_END, 56'h0};

  fsm_t       state_q, state_d;
  logic [4:0] lane_cnt;
  lane_t      buf_q [RATE_LANES];
  logic       pad_pend;
  logic [7:0] domain_q;
  logic [7:0] dom_in;
  logic [3:0] n_bytes;
  logic       at_last_lane;
  logic       exact_fit;
  lane_t      lane_pad;
  lane_t      spill_lane;

`ifdef KECCAK_PAD_DOMAIN_EN
  assign dom_in = pad_domain;
`else
  assign dom_in = DOMAIN_SHA3;
`endif

  assign n_bytes      = (s_bytes > 4'd8) ? 4'd8 : s_bytes;
  assign s_ready      = (state_q == FILL);
  assign at_last_lane = (lane_cnt == LAST_LANE);
  assign exact_fit    = s_last && (n_bytes == 4'd8) && at_last_lane;

  // A full final word on an earlier lane pushes the domain byte into the
  // next lane; if that next lane is the last rate lane it also takes 0x80.
  assign spill_lane = (lane_cnt + 5'd1 == LAST_LANE) ? (END_LANE | {56'h0, dom_in})
                                                     : {56'h0, dom_in};

  keccak_pad_lane u_pad_lane (
    .word          (s_data),
    .n             (n_bytes),
    .domain        (dom_in),
    .is_final_lane (s_last && at_last_lane && !exact_fit),
    .is_pad_lane   (s_last),
    .lane          (lane_pad)
  );

  for (genvar i = 0; i < 25; i++) begin : g_lane
    if (i < RATE_LANES) begin : g_rate
      assign blk_data[i/5][i%5] = buf_q[i];
    end else begin : g_cap
      assign blk_data[i/5][i%5] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (s_valid && (s_last || at_last_lane)) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (blk_ready) begin
          state_d = pad_pend ? PADBLK : FILL;
        end
      end
      PADBLK: state_d = SEND;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= FILL;
      lane_cnt  <= '0;
      pad_pend  <= 1'b0;
      domain_q  <= DOMAIN_SHA3;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      for (int i = 0; i < RATE_LANES; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        FILL: begin
          if (s_valid) begin
            buf_q[lane_cnt] <= lane_pad;
            lane_cnt        <= lane_cnt + 5'd1;
            if (s_last) begin
              domain_q  <= dom_in;
              blk_valid <= 1'b1;
              if (exact_fit) begin
                pad_pend <= 1'b1;
                blk_last <= 1'b0;
              end else begin
                blk_last <= 1'b1;
                if (n_bytes == 4'd8) begin
                  buf_q[lane_cnt + 5'd1] <= spill_lane;
                  if (lane_cnt + 5'd1 != LAST_LANE) begin
                    buf_q[LAST_LANE] <= END_LANE;
                  end
                end else if (!at_last_lane) begin
                  buf_q[LAST_LANE] <= END_LANE;
                end
              end
            end else if (at_last_lane) begin
              blk_valid <= 1'b1;
              blk_last  <= 1'b0;
            end
          end
        end
        SEND: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            lane_cnt  <= '0;
            for (int i = 0; i < RATE_LANES; i++) begin
              buf_q[i] <= '0;
            end
          end
        end
        PADBLK: begin
          // Buffer was cleared on the previous transfer.
          buf_q[0]         <= {56'h0, domain_q};
          buf_q[LAST_LANE] <= END_LANE;
          pad_pend         <= 1'b0;
          blk_valid        <= 1'b1;
          blk_last         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_pad_feeder.sv
module tb_keccak_pad_feeder;

  localparam int RL = 17;
  localparam int RB = RL * 8;

  logic                       clk = 1'b0;
  logic                       nrst = 1'b0;
  logic [63:0]                s_data = '0;
  logic                       s_valid = 1'b0;
  logic                       s_last = 1'b0;
  logic [3:0]                 s_bytes = '0;
  logic                       s_ready;
  logic [0:4][0:4][63:0]      blk_data;
  logic                       blk_valid;
  logic                       blk_last;
  logic                       blk_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_l[$];
  bit          exp_last[$];

  keccak_pad_feeder #(.WIDTH(64), .RATE_LANES(RL)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_bytes    (s_bytes),
`ifdef KECCAK_PAD_DOMAIN_EN
    .pad_domain (8'h06),
`endif
    .s_ready    (s_ready),
    .blk_data   (blk_data),
    .blk_valid  (blk_valid),
    .blk_last   (blk_last),
    .blk_ready  (blk_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks = n_checks + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference: SHA-3 pad10*1 over the byte string, then split into blocks.
  task automatic build_expected(input byte unsigned msg[$]);
    byte unsigned p[$];
    logic [63:0]  w;
    int           nblk;
    p = msg;
    p.push_back(8'h06);
    while (p.size() % RB != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / RB;
    exp_l.delete();
    exp_last.delete();
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 25; i++) begin
        w = '0;
        if (i < RL) begin
          for (int k = 0; k < 8; k++) w[8*k +: 8] = p[b*RB + 8*i + k];
        end
        exp_l.push_back(w);
      end
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  task automatic check_block(input int idx, input string tag);
    chk({tag, " block_index_in_range"}, 64'(idx < exp_last.size()), 64'd1);
    if (idx < exp_last.size()) begin
      for (int i = 0; i < 25; i++)
        chk($sformatf("%s blk%0d lane%0d", tag, idx, i), blk_data[i/5][i%5], exp_l[idx*25 + i]);
      chk($sformatf("%s blk%0d blk_last", tag, idx), blk_last, exp_last[idx]);
    end
  endtask

  task automatic collect(input int idx, input string tag, input int stall);
    int st;
    st = (stall < 0) ? $urandom_range(0, 3) : stall;
    check_block(idx, tag);
    for (int c = 0; c < st; c++) begin
      s_valid = 1'b1;
      s_data  = {$urandom, $urandom};
      s_last  = 1'($urandom_range(0, 1));
      s_bytes = 4'($urandom_range(0, 8));
      @(posedge clk);
      @(negedge clk);
      chk({tag, " stall s_ready"}, s_ready, 64'd0);
      chk({tag, " stall blk_valid"}, blk_valid, 64'd1);
    end
    if (st > 0) check_block(idx, {tag, " after stall"});
    blk_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    blk_ready = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    chk({tag, " blk_valid after transfer"}, blk_valid, 64'd0);
  endtask

  task automatic send_msg(input byte unsigned msg[$], input string tag, input bit garbage,
                          input int stall);
    int          len, nw, nb, blk, t;
    logic [63:0] d;
    bit          last, exp_v;
    build_expected(msg);
    len = msg.size();
    nw  = (len == 0) ? 1 : (len + 7) / 8;
    blk = 0;
    for (int w = 0; w < nw; w++) begin
      last = (w == nw - 1);
      nb   = last ? len - 8*w : 8;
      d    = garbage ? {$urandom, $urandom} : 64'h0;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = msg[8*w + k];
      chk({tag, " s_ready before word"}, s_ready, 64'd1);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      if (!last) s_bytes = 4'($urandom_range(0, 15));
      else if (nb == 8 && garbage) s_bytes = 4'($urandom_range(8, 15));
      else s_bytes = 4'(nb);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      exp_v = last || ((w + 1) % RL == 0);
      chk($sformatf("%s blk_valid after word%0d", tag, w), blk_valid, 64'(exp_v));
      if (blk_valid) begin
        collect(blk, tag, stall);
        blk++;
      end
    end
    while (blk < exp_last.size()) begin
      t = 0;
      while (!blk_valid && t < 8) begin
        @(negedge clk);
        t++;
      end
      chk({tag, " blk_valid wait"}, blk_valid, 64'd1);
      if (!blk_valid) break;
      collect(blk, tag, stall);
      blk++;
    end
    @(negedge clk);
    chk({tag, " idle s_ready"}, s_ready, 64'd1);
    chk({tag, " idle blk_valid"}, blk_valid, 64'd0);
  endtask

  function automatic void make_msg(input int len, output byte unsigned q[$]);
    q.delete();
    for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
  endfunction

  initial begin
    byte unsigned m[$];
    int           lens[16] = '{1, 7, 8, 9, 64, 120, 127, 128, 129, 135, 136, 137, 200, 271, 272, 273};

    repeat (3) @(negedge clk);
    chk("reset blk_valid", blk_valid, 64'd0);
    chk("reset blk_last", blk_last, 64'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("post-reset s_ready", s_ready, 64'd1);
    for (int i = 0; i < 25; i++) chk($sformatf("reset lane%0d", i), blk_data[i/5][i%5], 64'd0);

    m.delete();
    send_msg(m, "empty", 1'b1, 0);

    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, "abc", 1'b0, 0);

    make_msg(136, m);
    send_msg(m, "len136", 1'b1, -1);

    make_msg(135, m);
    send_msg(m, "len135", 1'b1, -1);

    make_msg(100, m);
    send_msg(m, "stall10", 1'b1, 10);

    // Reset in the middle of a message: the partial words must leave no residue.
    for (int w = 0; w < 5; w++) begin
      s_valid = 1'b1;
      s_data  = {$urandom, $urandom};
      s_last  = 1'b0;
      s_bytes = 4'd8;
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    nrst    = 1'b0;
    #2;
    chk("midreset blk_valid", blk_valid, 64'd0);
    chk("midreset lane0", blk_data[0][0], 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("midreset s_ready", s_ready, 64'd1);
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, "abc_after_reset", 1'b0, 0);

    foreach (lens[i]) begin
      make_msg(lens[i], m);
      send_msg(m, $sformatf("len%0d", lens[i]), 1'b1, -1);
    end

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(0, 400);
      make_msg(len, m);
      send_msg(m, $sformatf("rand%0d_len%0d", r, len), 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
